bram_ctrl: RTL and testbench

- Request/response initiator driving one single-port block RAM.
- Converts a valid/ready request channel (read or write) into BRAM port cycles.
- Tracks the fixed BRAM read latency and returns read data in order on a valid/ready response channel.
- Response FIFO plus credit counter ensure read data is never dropped under response backpressure; CPU/peripheral-side masters sit upstream, the BRAM wrapper downstream.

---
 rtl/bram_ctrl.sv | 147 ++++++++++++++
 tb/tb_bram_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_ctrl.sv
// bram_ctrl: request/response initiator for one single-port block RAM.
//
// Turns a valid/ready request channel (read or write) into BRAM port cycles.
// It tracks the fixed BRAM read latency and returns read data in request order
// on a valid/ready response channel. A credit counter limits the reads that
// are in flight plus the responses already buffered to the FIFO depth. Read
// data therefore always has a FIFO slot, even when the consumer stalls.
//
// Ports:
//   clk        in   rising-edge clock
//   aclr_n     in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid & req_ready
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address            [ADDR_]
//   req_wdata  in   write data              [DATA_]
//   rsp_valid  out  read data available
//   rsp_ready  in   consumer takes data when rsp_valid & rsp_ready
//   rsp_rdata  out  read data, request order [DATA_]
//   mem_we     out  BRAM write enable
//   mem_addr   out  BRAM address            [ADDR_]
//   mem_din    out  BRAM write data         [DATA_]
//   mem_dout   in   BRAM read data          [DATA_]

module bram_ctrl #(
    parameter int ADDR_      = 8,
    parameter int DATA_      = 8,
    parameter int LAT_       = 2,
    parameter int RSP_DEPTH_ = 4
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ADDR_-1:0] req_addr,
    input  logic [DATA_-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATA_-1:0] rsp_rdata,
    output logic             mem_we,
    output logic [ADDR_-1:0] mem_addr,
    output logic [DATA_-1:0] mem_din,
    input  logic [DATA_-1:0] mem_dout
);

    localparam int CW = $clog2(RSP_DEPTH_ + 1);
    localparam int PW = (RSP_DEPTH_ > 1) ? $clog2(RSP_DEPTH_) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH_);
    localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH_ - 1);

    generate
        if (LAT_ < 1 || LAT_ > 4) begin : g_lat_chk
            $error("bram_ctrl: LAT_ must be in 1..4");
        end
        if (RSP_DEPTH_ < LAT_ + 1) begin : g_depth_chk
            $error("bram_ctrl: RSP_DEPTH_ must be at least LAT_ + 1");
        end
    endgenerate

    logic             rdy_en;
    logic [LAT_-1:0]  pipe;
    logic [CW-1:0]    credit;
    logic [CW-1:0]    occ;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DATA_-1:0] fifo [RSP_DEPTH_];

    logic acc;
    logic rd_acc;
    logic push;
    logic pop;

    // rdy_en keeps req_ready low until the first edge after reset release.
    // The rest of req_ready depends only on the credit register, so upstream
    // logic never sees a combinational path from its own valid.
    assign req_ready = rdy_en && (credit < DEPTH_C);
    assign acc       = req_valid & req_ready;
    assign rd_acc    = acc & ~req_we;

    assign mem_we    = acc & req_we;
    assign mem_addr  = req_addr;
    assign mem_din   = req_wdata;

    // Bit LAT_-1 of the pipe marks the cycle in which mem_dout holds the data
    // of the read accepted LAT_ cycles earlier.
    assign push      = pipe[LAT_-1];
    assign rsp_valid = (occ != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = fifo[rd_ptr];

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            rdy_en <= 1'b0;
            pipe   <= '0;
        end else begin
            rdy_en  <= 1'b1;
            pipe[0] <= rd_acc;
            for (int i = 1; i < LAT_; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Credits cover reads in flight plus buffered responses.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            credit <= '0;
        end else begin
            case ({rd_acc, pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < RSP_DEPTH_; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (push) begin
                fifo[wr_ptr] <= mem_dout;
                wr_ptr       <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // The credit limit guarantees a free slot whenever read data arrives.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!aclr_n) push |-> (occ < DEPTH_C)
    );

endmodule

// File: tb/tb_bram_ctrl.sv
// tb_bram_ctrl: directed bench for bram_ctrl with a two-cycle BRAM model.
// The bench keeps a reference memory and an expected-response queue. Both are
// updated at each negative edge from the accepted handshakes.

module tb_bram_ctrl;

    logic       clk;
    logic       aclr_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    bram_ctrl #(.ADDR_(8), .DATA_(8), .LAT_(2), .RSP_DEPTH_(4)) dut (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM: address register, then output register (read latency 2).
    logic [7:0] bram [256];
    logic [7:0] addr_q;
    logic [7:0] dout_q;
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        addr_q <= mem_addr;
        dout_q <= bram[addr_q];
    end
    assign mem_dout = dout_q;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         we_cnt = 0;
    int         rsp_cnt = 0;
    int         rd_cnt = 0;
    logic [7:0] model [256];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        logic [7:0] e;
        if (aclr_n) begin
            if (mem_we) we_cnt++;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else e = 'x;
                chk("rsp_data", 32'(rsp_rdata), 32'(e));
                got_q.push_back(rsp_rdata);
                rsp_cnt++;
            end
            if (req_valid && req_ready) begin
                if (req_we) model[req_addr] = req_wdata;
                else begin
                    exp_q.push_back(model[req_addr]);
                    rd_cnt++;
                end
            end
        end
    endtask

    // Called 1ns after a rising edge; returns 1ns after the next one.
    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 100; t++) begin
            if (exp_q.size() == 0 && !rsp_valid) break;
            cyc();
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    int         nxt;
    int         ops;
    int         n0;
    logic       cur_we;
    logic [7:0] cur_addr;
    logic [7:0] cur_data;

    initial begin
        aclr_n    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Reset state
        #22;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        aclr_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", 32'(req_ready), 32'd1);

        // Single write then read of 0x05
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h05; req_wdata = 8'hA5;
        #1;
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h05);
        chk("wr_mem_din", 32'(mem_din), 32'hA5);
        cyc();
        req_we = 1'b0;
        #1;
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        cyc();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("lat_c1", 32'(rsp_valid), 32'd0);
        cyc();
        chk("lat_c2", 32'(rsp_valid), 32'd0);
        cyc();
        chk("lat_c3", 32'(rsp_valid), 32'd1);
        chk("lat_c3_data", 32'(rsp_rdata), 32'hA5);
        cyc();
        chk("single_popped", 32'(rsp_valid), 32'd0);
        chk("we_pulses", 32'(we_cnt), 32'd1);

        // Fill 0x00..0x0F, then 16 back-to-back reads
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_we = 1'b1;
            req_addr = 8'(i); req_wdata = 8'(i) ^ 8'h3C;
            cyc();
        end
        got_q.delete();
        n0 = rsp_cnt;
        for (int i = 0; i < 16; i++) begin
            req_we = 1'b0; req_addr = 8'(i);
            chk("b2b_ready", 32'(req_ready), 32'd1);
            cyc();
        end
        req_valid = 1'b0;
        chk("b2b_pops_early", 32'(rsp_cnt - n0), 32'd13);
        cyc(); cyc(); cyc();
        chk("b2b_pops_all", 32'(rsp_cnt - n0), 32'd16);
        chk("b2b_idle", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("b2b_order", 32'(got_q[i]), 32'(8'(i) ^ 8'h3C));
        end

        // Backpressure: 8 reads with rsp_ready low
        rsp_ready = 1'b0;
        nxt = 0;
        for (int k = 0; k < 8; k++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(nxt);
            if (req_ready) nxt++;
            cyc();
        end
        chk("bp_accepted", 32'(nxt), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_full_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        req_addr = 8'(nxt);
        chk("bp_ready_at_pop", 32'(req_ready), 32'd0);
        cyc();
        chk("bp_ready_after_pop", 32'(req_ready), 32'd1);
        for (int t = 0; t < 50 && nxt < 8; t++) begin
            req_addr = 8'(nxt);
            if (req_ready) nxt++;
            cyc();
        end
        req_valid = 1'b0;
        chk("bp_all_accepted", 32'(nxt), 32'd8);
        drain("bp_drain");

        // Interleaved write/read to 0x10
        got_q.delete();
        req_valid = 1'b1;
        req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'h11; cyc();
        req_we = 1'b0; cyc();
        req_we = 1'b1; req_wdata = 8'h22; cyc();
        req_we = 1'b0; cyc();
        req_valid = 1'b0;
        drain("ilv_drain");
        chk("ilv_count", 32'(got_q.size()), 32'd2);
        chk("ilv_first", 32'(got_q[0]), 32'h11);
        chk("ilv_second", 32'(got_q[1]), 32'h22);

        // Random traffic with random backpressure
        ops = 0;
        cur_we = 1'($urandom_range(0, 1));
        cur_addr = 8'($urandom_range(0, 16));
        cur_data = 8'($urandom_range(0, 255));
        for (int t = 0; t < 5000 && ops < 200; t++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            req_valid = 1'b1; req_we = cur_we; req_addr = cur_addr; req_wdata = cur_data;
            if (req_ready) begin
                ops++;
                cur_we = 1'($urandom_range(0, 1));
                cur_addr = 8'($urandom_range(0, 16));
                cur_data = 8'($urandom_range(0, 255));
            end
            cyc();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("rnd_ops_done", 32'(ops), 32'd200);
        drain("rnd_drain");
        chk("rnd_no_loss", 32'(rsp_cnt), 32'(rd_cnt));

        // Reset with 2 reads in flight and 2 responses buffered
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(k);
            cyc();
        end
        req_valid = 1'b0;
        chk("mid_buffered", 32'(rsp_valid), 32'd1);
        aclr_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
        exp_q.delete();
        cyc(); cyc();
        #2;
        aclr_n = 1'b1;
        rsp_ready = 1'b1;
        cyc();
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        n0 = rsp_cnt;
        for (int k = 0; k < 6; k++) begin
            chk("post_rst_quiet", 32'(rsp_valid), 32'd0);
            cyc();
        end
        chk("post_rst_no_pop", 32'(rsp_cnt - n0), 32'd0);
        rsp_ready = 1'b0;
        nxt = 0;
        for (int k = 0; k < 6; k++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(k);
            if (req_ready) nxt++;
            cyc();
        end
        req_valid = 1'b0;
        chk("post_rst_credits", 32'(nxt), 32'd4);
        rsp_ready = 1'b1;
        drain("post_rst_drain");
        got_q.delete();
        req_valid = 1'b1;
        req_we = 1'b1; req_addr = 8'h77; req_wdata = 8'h5A; cyc();
        req_we = 1'b0; cyc();
        req_valid = 1'b0;
        drain("post_rst_rd_drain");
        chk("post_rst_rd_count", 32'(got_q.size()), 32'd1);
        chk("post_rst_rd_data", 32'(got_q[0]), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
